// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared definitions for the 5-stage pipeline sequencer:
//                run-state encodings, default watchdog sizing and a
//                saturating-increment helper for the performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  // Run-state encodings; the debug unit decodes o_state with these values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Default watchdog sizing.
  localparam int STALL_LIMIT_DEF = 16;
  localparam int CNT_W_DEF       = 8;

  // Increment a 32-bit event counter, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_watchdog.sv
// ============================================================================
//  Module      : stall_watchdog
//  Description : Counts consecutive hazard-stall cycles while enabled and
//                raises o_trip on the cycle the count reaches STALL_LIMIT
//                with the stall still present. Counter is held at zero while
//                disabled and saturates rather than wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_stall,
  output logic o_trip
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STALL_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clears on any non-stall or disabled cycle, sticks at the limit.
  always_comb begin
    cnt_d = '0;
    if (i_en && i_stall) begin
      cnt_d = (cnt_q == C_LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Trip on the STALL_LIMIT-th consecutive stall cycle.
  assign o_trip = i_en && i_stall && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Central sequencer for the PC, IF/ID, ID/EX, EX/MEM and
//                MEM/WB pipeline registers. Arbitrates hazard stall, ID-stage
//                redirect and debug run/step/halt; drives per-stage enables
//                and flushes; tracks run state and a stall watchdog.
//                Optional build macro PIPE_CTRL_PERF_EN adds 32-bit advance,
//                stall and flush cycle counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hazard_stall,
  input  logic        i_branch_taken,
  input  logic        i_halt_retired,
  input  logic        i_dbg_run,
  input  logic        i_dbg_step,
  input  logic        i_dbg_halt,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_en,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_en,
  output logic [1:0]  o_state,
  output logic        o_step_done,
  output logic        o_stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] o_cyc_cnt,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       step_done_q;
  logic       timeout_q;
  logic       wd_trip;
  logic       advance;

  assign advance = (state_q == ST_RUN) || (state_q == ST_STEP);

  stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_W       (CNT_W)
  ) u_stall_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (state_q == ST_RUN),
    .i_stall (i_hazard_stall),
    .o_trip  (wd_trip)
  );

  // Stage controls: a stall freezes the front end and bubbles ID/EX, and it
  // overrides a redirect because the branch operands are not yet valid.
  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    if (advance) begin
      o_pc_en       = !i_hazard_stall;
      o_if_id_en    = !i_hazard_stall;
      o_if_id_flush = !i_hazard_stall && i_branch_taken;
      o_id_ex_en    = 1'b1;
      o_id_ex_flush = i_hazard_stall;
      o_ex_mem_en   = 1'b1;
      o_mem_wb_en   = 1'b1;
    end
  end

  // Next run state; commands not accepted in the current state are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dbg_run) begin
          state_d = ST_RUN;
        end else if (i_dbg_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_halt_retired) begin
          state_d = ST_DONE;
        end else if (i_dbg_halt || wd_trip) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_d = i_halt_retired ? ST_DONE : ST_IDLE;
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // State, step-completion pulse and sticky watchdog flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      step_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_done_q <= (state_q == ST_STEP);
      timeout_q   <= timeout_q || wd_trip;
    end
  end

  assign o_state         = state_q;
  assign o_step_done     = step_done_q;
  assign o_stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Performance counters advance only on RUN/STEP cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q   <= sat_inc32(cyc_q, advance);
      stall_q <= sat_inc32(stall_q, advance && i_hazard_stall);
      flush_q <= sat_inc32(flush_q, o_if_id_flush);
    end
  end

  assign o_cyc_cnt   = cyc_q;
  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl: directed scenarios
//                followed by randomized command/hazard traffic, compared each
//                cycle against a behavioural model of the run-state rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic rst, stall, br, hr, run, stp, hlt;

  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0] st;
  logic       step_done, timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_hazard_stall  (stall),
    .i_branch_taken  (br),
    .i_halt_retired  (hr),
    .i_dbg_run       (run),
    .i_dbg_step      (stp),
    .i_dbg_halt      (hlt),
    .o_pc_en         (pc_en),
    .o_if_id_en      (if_id_en),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_en      (id_ex_en),
    .o_id_ex_flush   (id_ex_flush),
    .o_ex_mem_en     (ex_mem_en),
    .o_mem_wb_en     (mem_wb_en),
    .o_state         (st),
    .o_step_done     (step_done),
    .o_stall_timeout (timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_cyc_cnt       (cyc_cnt),
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt)
`endif
  );

  // Reference model: mode uses the architectural o_state numbering.
  int     m_mode;         // 0 idle, 1 run, 2 step, 3 done
  int     m_stall_run;    // consecutive stall cycles seen while running
  bit     m_timeout;
  bit     m_step_done;
  longint m_cyc, m_stl, m_fl;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit s, input bit b, input bit h, input bit r, input bit p, input bit d);
    stall = s; br = b; hr = h; run = r; stp = p; hlt = d;
  endtask

  function automatic longint sat(input longint v, input bit en);
    return (en && v < 64'h0000_0000_FFFF_FFFF) ? v + 1 : v;
  endfunction

  // Check the current cycle against the model, then clock and advance the model.
  task automatic tick();
    bit adv, trip;
    int nxt;
    #2;
    adv = (m_mode == 1) || (m_mode == 2);
    check("state",     32'(st),          32'(m_mode));
    check("step_done", 32'(step_done),   32'(m_step_done));
    check("timeout",   32'(timeout),     32'(m_timeout));
    check("pc_en",     32'(pc_en),       32'(adv && !stall));
    check("if_id_en",  32'(if_id_en),    32'(adv && !stall));
    check("if_id_fl",  32'(if_id_flush), 32'(adv && !stall && br));
    check("id_ex_en",  32'(id_ex_en),    32'(adv));
    check("id_ex_fl",  32'(id_ex_flush), 32'(adv && stall));
    check("ex_mem_en", 32'(ex_mem_en),   32'(adv));
    check("mem_wb_en", 32'(mem_wb_en),   32'(adv));
`ifdef PIPE_CTRL_PERF_EN
    check("cyc_cnt",   cyc_cnt,   32'(m_cyc));
    check("stall_cnt", stall_cnt, 32'(m_stl));
    check("flush_cnt", flush_cnt, 32'(m_fl));
`endif
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_stall_run = 0; m_timeout = 0; m_step_done = 0;
      m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      trip = (m_mode == 1) && stall && (m_stall_run + 1 >= LIMIT);
      case (m_mode)
        0:       nxt = run ? 1 : (stp ? 2 : 0);
        1:       nxt = hr ? 3 : ((hlt || trip) ? 0 : 1);
        2:       nxt = hr ? 3 : 0;
        default: nxt = 3;
      endcase
      m_cyc       = sat(m_cyc, adv);
      m_stl       = sat(m_stl, adv && stall);
      m_fl        = sat(m_fl, adv && !stall && br);
      m_stall_run = (m_mode == 1 && stall) ? m_stall_run + 1 : 0;
      m_timeout   = m_timeout || trip;
      m_step_done = (m_mode == 2);
      m_mode      = nxt;
    end
    #1;
  endtask

  int bias;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    m_mode = 0; m_stall_run = 0; m_timeout = 0; m_step_done = 0;
    m_cyc = 0; m_stl = 0; m_fl = 0;
    tick();
    tick();
    rst = 1'b0;

    // Idle with no commands, then free-run.
    repeat (10) tick();
    set_in(0, 0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    // Three stall cycles then release.
    set_in(1, 0, 0, 0, 0, 0); repeat (3) tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    // Stall beats redirect, then redirect alone.
    set_in(1, 1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 0, 0); tick();
    // Step ignored in run; pause.
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    // Single step from idle.
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); repeat (3) tick();
    // Run and step together -> run.
    set_in(0, 0, 0, 1, 1, 0); tick();
    // Stall held past the watchdog limit.
    set_in(1, 0, 0, 0, 0, 0); repeat (LIMIT + 2) tick();
    set_in(0, 0, 0, 0, 0, 0); repeat (3) tick();
    // Resume, then halt retire and debug halt together -> done; run ignored.
    set_in(0, 0, 0, 1, 0, 0); tick();
    set_in(0, 1, 1, 0, 0, 1); tick();
    set_in(0, 0, 0, 1, 0, 0); repeat (3) tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    rst = 1'b1; set_in(0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0; repeat (2) tick();

    // Randomized traffic with phases of varying stall density.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       bias = 10;
          1:       bias = 50;
          default: bias = 98;
        endcase
      end
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 99) < bias);
      br    = ($urandom_range(0, 99) < 30);
      hr    = ($urandom_range(0, 199) == 0);
      run   = ($urandom_range(0, 99) < 6);
      stp   = ($urandom_range(0, 99) < 6);
      hlt   = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
